// File: rtl/button_event_defs.sv
// Shared constants for the button event generator and the seven-segment top level.
package button_event_defs;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;

    // 0.5 s hold and 0.1 s repeat at 100 MHz.
    localparam int unsigned HOLD_COUNT_DEFAULT   = 50_000_000;
    localparam int unsigned REPEAT_COUNT_DEFAULT = 10_000_000;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StPressed = ST_PRESSED,
        StRepeat  = ST_REPEAT
    } btn_state_e;

endpackage

// File: rtl/edge_detector.sv
// Registers the previous button level and produces combinational rise/fall strobes.
module edge_detector (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic in_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // prev resets high so a button held through reset is not seen as a fresh press.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i & ~prev_q;
    assign fall_o = ~in_i & prev_q;

endmodule

// File: rtl/button_event_generator.sv
// Turns a debounced button level into press/release/long-press/repeat pulses.
module button_event_generator
    import button_event_defs::*;
#(
    parameter int unsigned COUNTER_WIDTH = 26,
    parameter int unsigned HOLD_COUNT    = HOLD_COUNT_DEFAULT,
    parameter int unsigned REPEAT_COUNT  = REPEAT_COUNT_DEFAULT
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic in_i,
    input  logic enable_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam logic [COUNTER_WIDTH-1:0] HoldLast = COUNTER_WIDTH'(HOLD_COUNT - 1);
    localparam logic [COUNTER_WIDTH-1:0] RepeatLast =
        (REPEAT_COUNT == 0) ? '0 : COUNTER_WIDTH'(REPEAT_COUNT - 1);
    localparam bit RepeatEn = (REPEAT_COUNT != 0);

    logic rise;
    logic fall;

    edge_detector u_edge_detector (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .in_i     (in_i),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    btn_state_e               state_q;
    logic [COUNTER_WIDTH-1:0] counter_q;
    logic                     press_q;
    logic                     release_q;
    logic                     long_press_q;
    logic                     repeat_q;
    logic                     held_q;

    // FSM, hold/repeat timer and registered outputs. While PRESSED or REPEAT the level was
    // high on every prior edge, so in==0 there is exactly a falling strobe.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            if (!enable_i) begin
                state_q   <= StIdle;
                counter_q <= '0;
                held_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rise) begin
                            press_q   <= 1'b1;
                            held_q    <= 1'b1;
                            counter_q <= '0;
                            state_q   <= StPressed;
                        end
                    end
                    StPressed: begin
                        if (fall) begin
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                            counter_q <= '0;
                            state_q   <= StIdle;
                        end else if (counter_q == HoldLast) begin
                            long_press_q <= 1'b1;
                            counter_q    <= '0;
                            state_q      <= StRepeat;
                        end else begin
                            counter_q <= counter_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (fall) begin
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                            counter_q <= '0;
                            state_q   <= StIdle;
                        end else if (RepeatEn && counter_q == RepeatLast) begin
                            repeat_q  <= 1'b1;
                            counter_q <= '0;
                        end else if (RepeatEn) begin
                            counter_q <= counter_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        counter_q <= '0;
                        held_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_press_q;
    assign repeat_o     = repeat_q;
    assign held_o       = held_q;

endmodule

// File: tb/tb_button_event_generator.sv
// Bench for button_event_generator: directed scenarios plus random hold patterns, checked
// every cycle against a time-since-press reference model (repeat enabled and disabled).
module tb_button_event_generator;

    localparam int unsigned HOLD = 8;
    localparam int unsigned REP  = 4;
    localparam int unsigned CW   = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_lvl = 1'b0;
    logic enable = 1'b1;

    logic p0, r0, l0, rp0, h0;
    logic p1, r1, l1, rp1, h1;

    always #5 clock = ~clock;

    button_event_generator #(
        .COUNTER_WIDTH (CW),
        .HOLD_COUNT    (HOLD),
        .REPEAT_COUNT  (REP)
    ) u_dut_rep (
        .clock_i      (clock),
        .reset_ni     (reset_n),
        .in_i         (in_lvl),
        .enable_i     (enable),
        .press_o      (p0),
        .release_o    (r0),
        .long_press_o (l0),
        .repeat_o     (rp0),
        .held_o       (h0)
    );

    button_event_generator #(
        .COUNTER_WIDTH (CW),
        .HOLD_COUNT    (HOLD),
        .REPEAT_COUNT  (0)
    ) u_dut_norep (
        .clock_i      (clock),
        .reset_ni     (reset_n),
        .in_i         (in_lvl),
        .enable_i     (enable),
        .press_o      (p1),
        .release_o    (r1),
        .long_press_o (l1),
        .repeat_o     (rp1),
        .held_o       (h1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state per unit: 0 = REPEAT_COUNT 4, 1 = REPEAT_COUNT 0.
    bit         m_active [2];
    bit         m_prev   [2];
    int         m_t0     [2];
    logic [4:0] m_exp    [2];   // {press, release, long_press, repeat, held}

    // Pulse tallies per scenario: [unit][press, release, long, repeat]
    int tally [2][4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Events are a function of edges elapsed since the accepted press.
    task automatic model_step(input int u);
        int  rc;
        int  d;
        bit  rise;
        logic [4:0] e;
        rc = (u == 0) ? int'(REP) : 0;
        e  = '0;
        if (!reset_n) begin
            m_active[u] = 1'b0;
            m_prev[u]   = 1'b1;
        end else begin
            rise      = in_lvl && !m_prev[u];
            m_prev[u] = in_lvl;
            if (!enable) begin
                m_active[u] = 1'b0;
            end else if (!m_active[u]) begin
                if (rise) begin
                    e[4]        = 1'b1;
                    m_active[u] = 1'b1;
                    m_t0[u]     = cyc;
                end
            end else if (!in_lvl) begin
                e[3]        = 1'b1;
                m_active[u] = 1'b0;
            end else begin
                d = cyc - m_t0[u];
                if (d == int'(HOLD)) e[2] = 1'b1;
                if (rc != 0 && d > int'(HOLD) && ((d - int'(HOLD)) % rc) == 0) e[1] = 1'b1;
            end
        end
        e[0]     = m_active[u];
        m_exp[u] = e;
    endtask

    task automatic clear_tally();
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 4; k++) tally[u][k] = 0;
    endtask

    task automatic tick();
        logic [4:0] o0;
        logic [4:0] o1;
        @(posedge clock);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        o0 = {p0, r0, l0, rp0, h0};
        o1 = {p1, r1, l1, rp1, h1};
        check_eq("outs_rep", 32'(o0), 32'(m_exp[0]));
        check_eq("outs_norep", 32'(o1), 32'(m_exp[1]));
        for (int k = 0; k < 4; k++) begin
            if (o0[4-k] === 1'b1) tally[0][k]++;
            if (o1[4-k] === 1'b1) tally[1][k]++;
        end
    endtask

    task automatic hold_for(input logic lvl, input int n);
        in_lvl = lvl;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Scenario 1: button held through reset release, then dropped.
        clear_tally();
        reset_n = 1'b0;
        in_lvl  = 1'b1;
        tick();
        tick();
        check_eq("reset_outs", 32'({p0, r0, l0, rp0, h0}), 32'd0);
        reset_n = 1'b1;
        hold_for(1'b1, 5);
        hold_for(1'b0, 4);
        check_eq("s1_press", 32'(tally[0][0]), 32'd0);
        check_eq("s1_release", 32'(tally[0][1]), 32'd0);

        // Scenario 2: short press of 3 cycles.
        clear_tally();
        hold_for(1'b1, 3);
        hold_for(1'b0, 3);
        check_eq("s2_press", 32'(tally[0][0]), 32'd1);
        check_eq("s2_release", 32'(tally[0][1]), 32'd1);
        check_eq("s2_long", 32'(tally[0][2]), 32'd0);

        // Scenario 3: 20-cycle hold -> one long press, two repeats (none without repeat).
        clear_tally();
        hold_for(1'b1, 20);
        hold_for(1'b0, 4);
        check_eq("s3_long", 32'(tally[0][2]), 32'd1);
        check_eq("s3_repeat", 32'(tally[0][3]), 32'd2);
        check_eq("s3_release", 32'(tally[0][1]), 32'd1);
        check_eq("s3_norep_long", 32'(tally[1][2]), 32'd1);
        check_eq("s3_norep_repeat", 32'(tally[1][3]), 32'd0);

        // Scenario 4: fall on the threshold edge -> release wins.
        clear_tally();
        hold_for(1'b1, 8);
        hold_for(1'b0, 3);
        check_eq("s4_long", 32'(tally[0][2]), 32'd0);
        check_eq("s4_release", 32'(tally[0][1]), 32'd1);

        // Scenario 5: enable drop mid-REPEAT, button stays high on return.
        clear_tally();
        hold_for(1'b1, 14);
        enable = 1'b0;
        tick();
        check_eq("s5_held_off", 32'(h0), 32'd0);
        enable = 1'b1;
        hold_for(1'b1, 6);
        check_eq("s5_release", 32'(tally[0][1]), 32'd0);
        check_eq("s5_press_once", 32'(tally[0][0]), 32'd1);
        hold_for(1'b0, 2);
        hold_for(1'b1, 2);
        check_eq("s5_press_again", 32'(tally[0][0]), 32'd2);
        hold_for(1'b0, 2);

        // Scenario 6: one-edge reset mid-REPEAT with button kept high.
        clear_tally();
        hold_for(1'b1, 14);
        reset_n = 1'b0;
        tick();
        check_eq("s6_reset_outs", 32'({p0, r0, l0, rp0, h0}), 32'd0);
        reset_n = 1'b1;
        hold_for(1'b1, 6);
        check_eq("s6_press", 32'(tally[0][0]), 32'd1);
        hold_for(1'b0, 2);

        // Random hold patterns with occasional enable drops and resets.
        for (int s = 0; s < 200; s++) begin
            int len;
            in_lvl = 1'($urandom_range(0, 1));
            len    = int'($urandom_range(1, 25));
            for (int j = 0; j < len; j++) begin
                enable  = ($urandom_range(0, 23) != 0);
                reset_n = ($urandom_range(0, 79) != 0);
                tick();
                check_eq("one_pulse", 32'($countones({p0, r0, l0, rp0}) <= 1), 32'd1);
            end
        end
        enable  = 1'b1;
        reset_n = 1'b1;
        hold_for(1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
